// File: rtl/shift_cmd_gen.sv
// ----------------------------------------------------------------------------
// shift_cmd_gen
//   Input conditioner for the gearbox FSM. Each raw paddle/brake input is
//   passed through a 2-flop synchroniser and a counter debouncer. Debounced
//   paddle rising edges become single-cycle shift pulses. Simultaneous or
//   conflicting presses are rejected, and a hold-off window follows every
//   issued shift.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset (0 = reset)
//   btn_up_raw    in   raw up paddle, 1 = pressed
//   btn_down_raw  in   raw down paddle, 1 = pressed
//   brake_raw     in   raw brake switch, 1 = pressed
//   shift_up      out  one-cycle pulse: request one gear up
//   shift_down    out  one-cycle pulse: request one gear down
//   brake         out  debounced brake level
//   busy          out  high while the post-shift hold-off is active
// ----------------------------------------------------------------------------
module shift_cmd_gen #(
   parameter int unsigned DB_CNT  = 16,
   parameter int unsigned HOLDOFF = 32,
   parameter int unsigned CNT_W   = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   input  logic brake_raw,
   output logic shift_up,
   output logic shift_down,
   output logic brake,
   output logic busy
);

   // Input indices shared by the synchroniser/debounce arrays.
   localparam int unsigned IdxUp  = 0;
   localparam int unsigned IdxDn  = 1;
   localparam int unsigned IdxBrk = 2;
   localparam int unsigned NumIn  = 3;

   localparam logic [CNT_W-1:0] LDbCnt   = CNT_W'(DB_CNT);
   localparam logic [CNT_W-1:0] LHoldoff = CNT_W'(HOLDOFF);

   typedef enum logic [0:0] {
      StIdle,
      StHold
   } state_t;

   // -------------------------------------------------------------------------
   // Synchronise and debounce
   // -------------------------------------------------------------------------
   logic [NumIn-1:0] w_raw;
   logic [NumIn-1:0] r_sync1;
   logic [NumIn-1:0] r_sync2;
   logic [NumIn-1:0] r_db;
   logic [CNT_W-1:0] r_db_cnt  [NumIn];
   logic [CNT_W-1:0] w_cnt_inc [NumIn];

   assign w_raw[IdxUp]  = btn_up_raw;
   assign w_raw[IdxDn]  = btn_down_raw;
   assign w_raw[IdxBrk] = brake_raw;

   always_comb begin
      for (int i = 0; i < NumIn; i++) begin
         w_cnt_inc[i] = r_db_cnt[i] + CNT_W'(1);
      end
   end

   // The counter only advances while the synchronised level disagrees with
   // the accepted level; any agreement restarts it, so a glitch shorter than
   // DB_CNT cycles never flips the output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_db    <= '0;
         for (int i = 0; i < NumIn; i++) begin
            r_db_cnt[i] <= '0;
         end
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         for (int i = 0; i < NumIn; i++) begin
            if (r_sync2[i] != r_db[i]) begin
               if (w_cnt_inc[i] == LDbCnt) begin
                  r_db[i]     <= r_sync2[i];
                  r_db_cnt[i] <= '0;
               end else begin
                  r_db_cnt[i] <= w_cnt_inc[i];
               end
            end else begin
               r_db_cnt[i] <= '0;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Paddle edge detect
   // -------------------------------------------------------------------------
   logic [1:0] r_db_prev;
   logic       w_rise_up;
   logic       w_rise_dn;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_db_prev <= '0;
      end else begin
         r_db_prev <= r_db[IdxDn:IdxUp];
      end
   end

   assign w_rise_up = r_db[IdxUp] & ~r_db_prev[IdxUp];
   assign w_rise_dn = r_db[IdxDn] & ~r_db_prev[IdxDn];

   // -------------------------------------------------------------------------
   // Shift FSM
   // -------------------------------------------------------------------------
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [CNT_W-1:0] w_hold_nxt;
   logic             r_shift_up;
   logic             r_shift_dn;
   logic             w_shift_up_nxt;
   logic             w_shift_dn_nxt;
   logic             w_pulse;

   assign w_pulse = r_shift_up | r_shift_dn;

   always_comb begin
      w_state_nxt    = r_state;
      w_hold_nxt     = r_hold_cnt;
      w_shift_up_nxt = 1'b0;
      w_shift_dn_nxt = 1'b0;
      unique case (r_state)
         StIdle: begin
            // A rise while the other paddle is already held is a conflict and
            // is dropped, as is a simultaneous rise on both paddles.
            if (w_rise_up && !w_rise_dn && !r_db[IdxDn]) begin
               w_shift_up_nxt = 1'b1;
               w_hold_nxt     = LHoldoff;
               w_state_nxt    = StHold;
            end else if (w_rise_dn && !w_rise_up && !r_db[IdxUp]) begin
               w_shift_dn_nxt = 1'b1;
               w_hold_nxt     = LHoldoff;
               w_state_nxt    = StHold;
            end
         end
         StHold: begin
            // The pulse cycle itself is not part of the hold-off count, so
            // busy covers exactly HOLDOFF cycles after the pulse.
            if (!w_pulse) begin
               if (r_hold_cnt <= CNT_W'(1)) begin
                  w_hold_nxt  = '0;
                  w_state_nxt = StIdle;
               end else begin
                  w_hold_nxt = r_hold_cnt - CNT_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = StIdle;
            w_hold_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= StIdle;
         r_hold_cnt <= '0;
         r_shift_up <= 1'b0;
         r_shift_dn <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_shift_up <= w_shift_up_nxt;
         r_shift_dn <= w_shift_dn_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign shift_up   = r_shift_up;
   assign shift_down = r_shift_dn;
   assign brake      = r_db[IdxBrk];
   assign busy       = (r_state == StHold) & ~w_pulse;

endmodule

// File: tb/tb_shift_cmd_gen.sv
module tb_shift_cmd_gen;

   localparam int DB = 4;
   localparam int HO = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic up_raw = 1'b0;
   logic dn_raw = 1'b0;
   logic brk_raw = 1'b0;
   logic shift_up;
   logic shift_down;
   logic brake;
   logic busy;

   shift_cmd_gen #(
      .DB_CNT (DB),
      .HOLDOFF(HO),
      .CNT_W  (16)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .btn_up_raw  (up_raw),
      .btn_down_raw(dn_raw),
      .brake_raw   (brk_raw),
      .shift_up    (shift_up),
      .shift_down  (shift_down),
      .brake       (brake),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [1:0] kind;   // {shift_up, shift_down}
   } pulse_t;

   typedef struct {
      int   cyc;
      logic lvl;
   } brk_t;

   pulse_t q_pulse[$];
   brk_t   q_brake[$];

   int   cyc = 0;
   int   n_vec = 0;
   int   n_fail = 0;
   int   busy_lo = 1;
   int   busy_hi = 0;
   logic exp_brake = 1'b0;

   // Raw input driven now is first sampled at edge cyc+1; pulse lands at
   // edge (cyc+1)+DB+2, level outputs change at edge (cyc+1)+DB+1.
   task automatic expect_pulse(input logic [1:0] kind);
      pulse_t e;
      e.cyc  = cyc + DB + 3;
      e.kind = kind;
      q_pulse.push_back(e);
   endtask

   task automatic expect_brake(input logic lvl);
      brk_t e;
      e.cyc = cyc + DB + 2;
      e.lvl = lvl;
      q_brake.push_back(e);
   endtask

   // Advance one clock and check every output against the scoreboard.
   task automatic tick();
      pulse_t e;
      logic   exp_busy;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (q_pulse.size() > 0 && q_pulse[0].cyc < cyc) begin
         n_vec++;
         n_fail++;
         $display("FAIL missing_pulse: got no pulse, required kind %b at cycle %0d (now %0d)",
                  q_pulse[0].kind, q_pulse[0].cyc, cyc);
         void'(q_pulse.pop_front());
      end
      if (shift_up || shift_down) begin
         n_vec++;
         if (q_pulse.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: got {up,dn}=%b at cycle %0d, required none",
                     {shift_up, shift_down}, cyc);
         end else begin
            e = q_pulse.pop_front();
            if ({shift_up, shift_down} !== e.kind || cyc != e.cyc) begin
               n_fail++;
               $display("FAIL pulse: got {up,dn}=%b at cycle %0d, required %b at cycle %0d",
                        {shift_up, shift_down}, cyc, e.kind, e.cyc);
            end
            busy_lo = e.cyc + 1;
            busy_hi = e.cyc + HO;
         end
      end
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      n_vec++;
      if (busy !== exp_busy) begin
         n_fail++;
         $display("FAIL busy: got %b at cycle %0d, required %b", busy, cyc, exp_busy);
      end
      if (q_brake.size() > 0 && q_brake[0].cyc == cyc) begin
         exp_brake = q_brake[0].lvl;
         void'(q_brake.pop_front());
      end
      n_vec++;
      if (brake !== exp_brake) begin
         n_fail++;
         $display("FAIL brake: got %b at cycle %0d, required %b", brake, cyc, exp_brake);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_drained(input string name);
      n_vec++;
      if (q_pulse.size() != 0 || q_brake.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drained: got %0d pulses and %0d brake events pending, required 0",
                  name, q_pulse.size(), q_brake.size());
         q_pulse.delete();
         q_brake.delete();
      end
   endtask

   task automatic test_reset();
      #1;
      n_vec++;
      if ({shift_up, shift_down, brake, busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b, required 0000",
                  {shift_up, shift_down, brake, busy});
      end
      ticks(3);
      reset = 1'b1;
      ticks(3);
   endtask

   task automatic test_single_up();
      up_raw = 1'b1;
      expect_pulse(2'b10);
      ticks(30);
      up_raw = 1'b0;
      ticks(20);
      check_drained("single_up");
   endtask

   task automatic test_glitch();
      up_raw = 1'b1;
      ticks(DB - 1);
      up_raw = 1'b0;
      ticks(15);
      check_drained("glitch");
   endtask

   task automatic test_simultaneous();
      up_raw = 1'b1;
      dn_raw = 1'b1;
      ticks(20);
      up_raw = 1'b0;
      dn_raw = 1'b0;
      ticks(20);
      check_drained("simultaneous");
   endtask

   task automatic test_repress_busy();
      // Minimal press/release/re-press: the re-press debounces inside hold-off.
      up_raw = 1'b1;
      expect_pulse(2'b10);
      ticks(DB);
      up_raw = 1'b0;
      ticks(DB);
      up_raw = 1'b1;
      ticks(20);
      up_raw = 1'b0;
      ticks(12);
      up_raw = 1'b1;
      expect_pulse(2'b10);
      ticks(20);
      up_raw = 1'b0;
      ticks(15);
      check_drained("repress_busy");
   endtask

   task automatic test_conflict();
      dn_raw = 1'b1;
      expect_pulse(2'b01);
      ticks(20);
      up_raw = 1'b1;
      ticks(20);
      up_raw = 1'b0;
      dn_raw = 1'b0;
      ticks(20);
      up_raw = 1'b1;
      expect_pulse(2'b10);
      ticks(20);
      dn_raw = 1'b1;
      ticks(20);
      up_raw = 1'b0;
      dn_raw = 1'b0;
      ticks(20);
      check_drained("conflict");
   endtask

   task automatic test_brake_busy();
      up_raw = 1'b1;
      expect_pulse(2'b10);
      ticks(2);
      brk_raw = 1'b1;
      expect_brake(1'b1);
      ticks(20);
      brk_raw = 1'b0;
      expect_brake(1'b0);
      ticks(10);
      up_raw = 1'b0;
      ticks(15);
      check_drained("brake_busy");
   endtask

   task automatic test_reset_hold();
      up_raw = 1'b1;
      expect_pulse(2'b10);
      ticks(10);
      #1 reset = 1'b0;
      #1;
      n_vec++;
      if ({shift_up, shift_down, brake, busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mid_hold: got %b, required 0000",
                  {shift_up, shift_down, brake, busy});
      end
      busy_lo   = 1;
      busy_hi   = 0;
      exp_brake = 1'b0;
      q_pulse.delete();
      q_brake.delete();
      ticks(3);
      reset = 1'b1;
      expect_pulse(2'b10);
      ticks(20);
      up_raw = 1'b0;
      ticks(15);
      check_drained("reset_hold");
   endtask

   initial begin
      test_reset();
      test_single_up();
      test_glitch();
      test_simultaneous();
      test_repress_busy();
      test_conflict();
      test_brake_busy();
      test_reset_hold();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
